// File: rtl/rsaasip_isa_pkg.sv
// rtl/rsaasip_isa_pkg.sv - ISA opcodes, field positions and loader FSM states
package rsaasip_isa_pkg;

    localparam logic [2:0] OP_SET   = 3'b000;
    localparam logic [2:0] OP_LDPX  = 3'b001;
    localparam logic [2:0] OP_MODEX = 3'b010;
    localparam logic [2:0] OP_STPX  = 3'b011;
    localparam logic [2:0] OP_CMPEQ = 3'b100;
    localparam logic [2:0] OP_JEQ   = 3'b101;
    localparam logic [2:0] OP_J     = 3'b110;
    localparam logic [2:0] OP_ADD   = 3'b111;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 13;
    localparam int RD_HI   = 12;
    localparam int RD_LO   = 10;
    localparam int RS1_HI  = 9;
    localparam int RS1_LO  = 7;
    localparam int RS2_HI  = 6;
    localparam int RS2_LO  = 4;
    localparam int IMM_HI  = 9;
    localparam int IMM_LO  = 0;
    localparam int ADDR_HI = 12;
    localparam int ADDR_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

endpackage

// File: rtl/instr_field_encoder.sv
// rtl/instr_field_encoder.sv - packs per-field instruction requests into one ISA word
module instr_field_encoder
    import rsaasip_isa_pkg::*;
#(
    parameter int ARQ    = 16,
    parameter int ADDR_W = 13
) (
    input  logic [2:0]        opcode,
    input  logic [2:0]        srcdest,
    input  logic [2:0]        src1,
    input  logic [2:0]        src2,
    input  logic [9:0]        imm,
    input  logic [ADDR_W-1:0] addr,
    output logic [ARQ-1:0]    word,
    output logic              format_err
);

    always_comb begin
        word       = '0;
        format_err = 1'b0;
        word[OPC_HI:OPC_LO] = opcode;
        case (opcode)
            OP_MODEX, OP_CMPEQ: begin
                word[RD_HI:RD_LO]   = srcdest;
                word[RS1_HI:RS1_LO] = src1;
                word[RS2_HI:RS2_LO] = src2;
            end
            OP_LDPX, OP_STPX: begin
                word[RD_HI:RD_LO]   = srcdest;
                word[RS1_HI:RS1_LO] = src1;
            end
            OP_JEQ, OP_J: begin
                word[ADDR_HI:ADDR_LO] = addr;
            end
            default: begin
                // SET/ADD are two-operand: the source must name the destination
                word[RD_HI:RD_LO]   = srcdest;
                word[IMM_HI:IMM_LO] = imm;
                format_err          = (src1 != srcdest);
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - streams encoded instructions into instruction memory
module instr_encoder_loader
    import rsaasip_isa_pkg::*;
#(
    parameter int ARQ       = 16,
    parameter int ADDR_W    = 13,
    parameter int MEM_WORDS = 8192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        opcode,
    input  logic [2:0]        srcdest,
    input  logic [2:0]        src1,
    input  logic [2:0]        src2,
    input  logic [9:0]        imm,
    input  logic [ADDR_W-1:0] addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ARQ-1:0]    mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_WORDS - 1);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              err_q, err_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ARQ-1:0]    mem_wdata_q, mem_wdata_d;

    logic [ARQ-1:0]    enc_word;
    logic              enc_err;
    logic              at_last;

    instr_field_encoder #(
        .ARQ    (ARQ),
        .ADDR_W (ADDR_W)
    ) u_enc (
        .opcode     (opcode),
        .srcdest    (srcdest),
        .src1       (src1),
        .src2       (src2),
        .imm        (imm),
        .addr       (addr),
        .word       (enc_word),
        .format_err (enc_err)
    );

    assign at_last = ({1'b0, wr_ptr_q} == LAST_ADDR);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        word_count_d = word_count_q;
        err_d        = err_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    wr_ptr_d     = base_addr;
                    word_count_d = '0;
                    err_d        = 1'b0;
                    if ({1'b0, base_addr} >= MEM_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = wr_ptr_q;
                    mem_wdata_d  = enc_word;
                    wr_ptr_d     = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    word_count_d = word_count_q + {{ADDR_W{1'b0}}, 1'b1};
                    if (enc_err) begin
                        err_d = 1'b1;
                    end
                    // The top word ends the session; without in_last it is an overflow
                    if (at_last) begin
                        if (!in_last) begin
                            err_d = 1'b1;
                        end
                        state_d = ST_DRAIN;
                    end else if (in_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            err_q        <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign in_ready   = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;
    assign word_count = word_count_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed scoreboard bench for instr_encoder_loader
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [12:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  opcode, srcdest, src1, src2;
    logic [9:0]  imm;
    logic [12:0] addr;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy, done, err;
    logic [13:0] word_count;

    int vectors = 0;
    int miscompares = 0;
    logic [28:0] sb[$];
    logic [12:0] exp_ptr;

    instr_encoder_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .opcode     (opcode),
        .srcdest    (srcdest),
        .src1       (src1),
        .src2       (src2),
        .imm        (imm),
        .addr       (addr),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_write: observed addr %h data %h expected no write", mem_addr, mem_wdata);
            end
            if (sb.size() != 0) begin
                logic [28:0] e;
                e = sb.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[28:16]));
                check("wr_data", 32'(mem_wdata), 32'(e[15:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [12:0] base);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        exp_ptr = base;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [9:0] im, input logic [12:0] ad,
                        input logic last, input logic exp_ready, input logic [15:0] exp_word);
        opcode = op; srcdest = rd; src1 = rs1; src2 = rs2; imm = im; addr = ad;
        in_last = last;
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        if (exp_ready) begin
            sb.push_back({exp_ptr, exp_word});
            exp_ptr = exp_ptr + 13'd1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        opcode = '0; srcdest = '0; src1 = '0; src2 = '0; imm = '0; addr = '0; exp_ptr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single SET, exact done timing
        do_start(13'h0000);
        send(3'b000, 3'd3, 3'd3, 3'd0, 10'h02A, 13'h0, 1'b1, 1'b1, 16'h0C2A);
        @(negedge clk);
        check("t1_done_early", 32'(done), 32'd0);
        check("t1_busy_drain", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_done", 32'(done), 32'd1);
        check("t1_count", 32'(word_count), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_idle_ready", 32'(in_ready), 32'd0);

        // back-to-back mixed formats
        do_start(13'h0010);
        send(3'b010, 3'd1, 3'd2, 3'd5, 10'h3FF, 13'h1ABC, 1'b0, 1'b1, 16'h4550);
        send(3'b001, 3'd7, 3'd4, 3'd6, 10'h000, 13'h0000, 1'b0, 1'b1, 16'h3E00);
        send(3'b110, 3'd5, 3'd1, 3'd2, 10'h155, 13'h0123, 1'b0, 1'b1, 16'hC123);
        send(3'b101, 3'd0, 3'd0, 3'd0, 10'h000, 13'h1FFF, 1'b1, 1'b1, 16'hBFFF);
        wait_done();
        check("t2_count", 32'(word_count), 32'd4);
        check("t2_err", 32'(err), 32'd0);

        // ADD with src1 != srcdest: sticky err, cleared by next start
        do_start(13'h0000);
        send(3'b111, 3'd2, 3'd5, 3'd0, 10'h001, 13'h0, 1'b1, 1'b1, 16'hE801);
        @(negedge clk);
        check("t3_err_set", 32'(err), 32'd1);
        wait_done();
        check("t3_err_done", 32'(err), 32'd1);
        @(negedge clk);
        check("t3_err_idle", 32'(err), 32'd1);
        do_start(13'h0000);
        @(negedge clk);
        check("t3_err_clr", 32'(err), 32'd0);
        @(posedge clk); #1;
        send(3'b000, 3'd1, 3'd1, 3'd0, 10'h000, 13'h0, 1'b1, 1'b1, 16'h0400);
        wait_done();

        // overflow at top of memory
        do_start(13'h1FFE);
        send(3'b000, 3'd1, 3'd1, 3'd0, 10'h005, 13'h0, 1'b0, 1'b1, 16'h0405);
        send(3'b100, 3'd1, 3'd2, 3'd3, 10'h000, 13'h0, 1'b0, 1'b1, 16'h8530);
        send(3'b000, 3'd2, 3'd2, 3'd0, 10'h001, 13'h0, 1'b0, 1'b0, 16'h0000);
        wait_done();
        check("t4_err", 32'(err), 32'd1);
        check("t4_count", 32'(word_count), 32'd2);

        // gap in in_valid plus ignored start during RUN
        do_start(13'h0100);
        send(3'b011, 3'd2, 3'd6, 3'd7, 10'h0AA, 13'h0F0F, 1'b0, 1'b1, 16'h6B00);
        start = 1'b1;
        base_addr = 13'h0555;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t5_gap_we", 32'(mem_we), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        send(3'b000, 3'd5, 3'd5, 3'd3, 10'h3FF, 13'h1234, 1'b0, 1'b1, 16'h17FF);
        send(3'b100, 3'd7, 3'd7, 3'd7, 10'h000, 13'h0000, 1'b1, 1'b1, 16'h9FF0);
        wait_done();
        check("t5_count", 32'(word_count), 32'd3);
        check("t5_err", 32'(err), 32'd0);

        // reset right after a transfer drops the pending request
        do_start(13'h0020);
        send(3'b001, 3'd1, 3'd1, 3'd0, 10'h000, 13'h0, 1'b0, 1'b1, 16'h2480);
        opcode = 3'b000; srcdest = 3'd4; src1 = 3'd4; imm = 10'h011;
        in_valid = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_mem_we", 32'(mem_we), 32'd0);
        check("t6_mem_addr", 32'(mem_addr), 32'd0);
        check("t6_mem_wdata", 32'(mem_wdata), 32'd0);
        check("t6_count", 32'(word_count), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("t6_idle_we", 32'(mem_we), 32'd0);
        check("t6_idle_ready", 32'(in_ready), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
